// File: rtl/spio_hss_multiplexer_pkt_issue.sv
// rtl/spio_hss_multiplexer_pkt_issue.sv - packet requester and frame packer for the HSS multiplexer store
module spio_hss_multiplexer_pkt_issue #(
    parameter int PKT_BITS = 72,
    parameter int SEQ_BITS = 7,
    parameter int SLOTS    = 4,
    parameter int CNT_BITS = $clog2(SLOTS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [SEQ_BITS-1:0]       bpkt_seq,
    output logic                      bpkt_rq,
    input  logic                      bpkt_gt,
    input  logic [PKT_BITS-1:0]       bpkt_data,
    input  logic                      vld_nak,
    input  logic [SEQ_BITS-1:0]       ack_seq,
    output logic [SLOTS*PKT_BITS-1:0] frm_data,
    output logic [CNT_BITS-1:0]       frm_cnt,
    output logic [SEQ_BITS-1:0]       frm_seq,
    output logic                      frm_vld,
    input  logic                      frm_rdy
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] LAST_SLOT = CNT_BITS'(SLOTS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [SEQ_BITS-1:0] seq;
    logic [CNT_BITS-1:0] cnt;
    logic                handshake;

    assign handshake = frm_vld && frm_rdy;
    assign bpkt_rq   = (state == ST_REQ);
    assign bpkt_seq  = seq;
    assign frm_cnt   = cnt;

    // Next-state decode; a nak overrides every other transition and restarts requesting.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bpkt_gt) begin
                    state_nxt = (cnt == LAST_SLOT) ? ST_SEND : ST_REQ;
                end else begin
                    state_nxt = (cnt != '0) ? ST_SEND : ST_REQ;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_REQ;
        endcase
        if (vld_nak) begin
            state_nxt = ST_REQ;
        end
    end

    // State register; frm_vld is registered so it rises on the cycle SEND is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_REQ;
            frm_vld <= 1'b0;
        end else begin
            state   <= state_nxt;
            frm_vld <= (state_nxt == ST_SEND);
        end
    end

    // Slot packing, sequence tracking and nak rewind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq      <= '0;
            cnt      <= '0;
            frm_data <= '0;
            frm_seq  <= '0;
        end else if (vld_nak) begin
            seq      <= ack_seq;
            cnt      <= '0;
            frm_data <= '0;
        end else begin
            if (state == ST_WAIT && bpkt_gt) begin
                for (int i = 0; i < SLOTS; i++) begin
                    if (cnt == CNT_BITS'(i)) begin
                        frm_data[i*PKT_BITS +: PKT_BITS] <= bpkt_data;
                    end
                end
                if (cnt == '0) begin
                    frm_seq <= seq;
                end
                seq <= seq + SEQ_BITS'(1);
                cnt <= cnt + CNT_BITS'(1);
            end else if (state == ST_SEND && handshake) begin
                cnt      <= '0;
                frm_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spio_hss_multiplexer_pkt_issue.sv
// tb/tb_spio_hss_multiplexer_pkt_issue.sv - scoreboard bench for the packet issue / frame packer
module tb_spio_hss_multiplexer_pkt_issue;

    localparam int PKT_BITS = 72;
    localparam int SEQ_BITS = 7;
    localparam int SLOTS    = 4;
    localparam int CNT_BITS = $clog2(SLOTS + 1);
    localparam int FRM_BITS = SLOTS * PKT_BITS;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [SEQ_BITS-1:0] bpkt_seq;
    logic                bpkt_rq;
    logic                bpkt_gt = 1'b0;
    logic [PKT_BITS-1:0] bpkt_data = '0;
    logic                vld_nak = 1'b0;
    logic [SEQ_BITS-1:0] ack_seq = '0;
    logic [FRM_BITS-1:0] frm_data;
    logic [CNT_BITS-1:0] frm_cnt;
    logic [SEQ_BITS-1:0] frm_seq;
    logic                frm_vld;
    logic                frm_rdy = 1'b0;

    spio_hss_multiplexer_pkt_issue #(
        .PKT_BITS(PKT_BITS),
        .SEQ_BITS(SEQ_BITS),
        .SLOTS   (SLOTS),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bpkt_seq (bpkt_seq),
        .bpkt_rq  (bpkt_rq),
        .bpkt_gt  (bpkt_gt),
        .bpkt_data(bpkt_data),
        .vld_nak  (vld_nak),
        .ack_seq  (ack_seq),
        .frm_data (frm_data),
        .frm_cnt  (frm_cnt),
        .frm_seq  (frm_seq),
        .frm_vld  (frm_vld),
        .frm_rdy  (frm_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FRM_BITS-1:0] data;
        logic [CNT_BITS-1:0] cnt;
        logic [SEQ_BITS-1:0] seq;
    } frame_t;

    frame_t              sb_q[$];
    int                  n_checks = 0;
    int                  n_pass   = 0;

    logic [SEQ_BITS-1:0] m_seq   = '0;
    logic [SEQ_BITS-1:0] m_fseq  = '0;
    int                  m_cnt   = 0;
    logic [FRM_BITS-1:0] m_slots = '0;

    task automatic check(input string tag, input logic [FRM_BITS-1:0] got, input logic [FRM_BITS-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_frame();
        frame_t f;
        f.data = m_slots;
        f.cnt  = CNT_BITS'(m_cnt);
        f.seq  = m_fseq;
        sb_q.push_back(f);
        m_cnt   = 0;
        m_slots = '0;
    endtask

    // Entered at a negedge with the DUT in REQ; leaves at the negedge after the WAIT cycle.
    task automatic req_grant(input bit give, input logic [PKT_BITS-1:0] d);
        check("rq_req", bpkt_rq, 1);
        check("seq_req", bpkt_seq, m_seq);
        check("vld_idle", frm_vld, 0);
        @(negedge clk);
        check("rq_wait", bpkt_rq, 0);
        bpkt_gt   = give;
        bpkt_data = d;
        if (give) begin
            m_slots[m_cnt*PKT_BITS +: PKT_BITS] = d;
            if (m_cnt == 0) m_fseq = m_seq;
            m_seq = m_seq + SEQ_BITS'(1);
            m_cnt++;
            if (m_cnt == SLOTS) push_frame();
        end else if (m_cnt > 0) begin
            push_frame();
        end
        @(negedge clk);
        bpkt_gt   = 1'b0;
        bpkt_data = '0;
    endtask

    task automatic take_frame(input int hold);
        frame_t e;
        int     t;
        t = 0;
        while (!frm_vld && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("vld_latency", t, 0);
        check("sb_size", sb_q.size(), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        repeat (hold) begin
            check("hold_vld", frm_vld, 1);
            check("hold_data", frm_data, e.data);
            check("hold_rq", bpkt_rq, 0);
            @(negedge clk);
        end
        frm_rdy = 1'b1;
        check("frm_vld", frm_vld, 1);
        check("frm_data", frm_data, e.data);
        check("frm_cnt", frm_cnt, e.cnt);
        check("frm_seq", frm_seq, e.seq);
        @(negedge clk);
        frm_rdy = 1'b0;
        check("vld_fall", frm_vld, 0);
        check("rq_after", bpkt_rq, 1);
    endtask

    // Nak in a REQ cycle, then a stray grant in the REQ cycle that follows, which must be ignored.
    task automatic do_nak(input logic [SEQ_BITS-1:0] ack);
        vld_nak = 1'b1;
        ack_seq = ack;
        m_seq   = ack;
        m_cnt   = 0;
        m_slots = '0;
        @(negedge clk);
        vld_nak = 1'b0;
        check("nak_rq", bpkt_rq, 1);
        check("nak_seq", bpkt_seq, ack);
        check("nak_vld", frm_vld, 0);
        bpkt_gt   = 1'b1;
        bpkt_data = PKT_BITS'(72'hEE);
        @(negedge clk);
        bpkt_gt   = 1'b0;
        bpkt_data = '0;
        check("nak_wait_rq", bpkt_rq, 0);
        check("nak_wait_vld", frm_vld, 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_vld", frm_vld, 0);
        check("rst_data", frm_data, 0);
        check("rst_cnt", frm_cnt, 0);
        check("rst_fseq", frm_seq, 0);
        check("rst_seq", bpkt_seq, 0);
        rst = 1'b0;

        // Empty store: request toggles, nothing advances.
        for (int i = 0; i < 10; i++) req_grant(1'b0, '0);

        // Eight grants make two full frames.
        for (int i = 0; i < 8; i++) begin
            req_grant(1'b1, PKT_BITS'(8'h10 + i));
            if (i == 3 || i == 7) take_frame(0);
        end
        check("seq_after8", bpkt_seq, 8);

        // Single packet at seq 5 then a miss gives a partial frame.
        do_nak(7'd5);
        req_grant(1'b1, PKT_BITS'(8'hAA));
        req_grant(1'b0, '0);
        take_frame(0);

        // Full frame held off by frm_rdy for 10 cycles.
        for (int i = 0; i < SLOTS; i++) req_grant(1'b1, PKT_BITS'(8'h30 + i));
        take_frame(10);

        // Nak with a partial frame pending discards it and rewinds to 2.
        do_nak(7'd4);
        req_grant(1'b1, PKT_BITS'(8'h40));
        req_grant(1'b1, PKT_BITS'(8'h41));
        check("pre_nak_seq", bpkt_seq, 6);
        do_nak(7'd2);
        for (int i = 0; i < SLOTS; i++) req_grant(1'b1, PKT_BITS'(8'h50 + i));
        take_frame(0);

        // Sequence wrap: 126, 127, 0, then a miss.
        do_nak(7'd126);
        for (int i = 0; i < 3; i++) req_grant(1'b1, PKT_BITS'(8'h60 + i));
        req_grant(1'b0, '0);
        take_frame(0);
        req_grant(1'b0, '0);
        check("seq_wrapped", bpkt_seq, 1);

        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
